// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and saturating-counter helpers for the branch predictor
package bp_pkg;

  localparam int INSN_BYTES_DEF = 4;
  localparam int CTR_MAX_BITS   = 4;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Weakly not-taken: the value just below the MSB flip.
  function automatic logic [CTR_MAX_BITS-1:0] ctr_init(input int bits);
    return CTR_MAX_BITS'((1 << (bits - 1)) - 1);
  endfunction

  function automatic logic [CTR_MAX_BITS-1:0] ctr_next(input logic [CTR_MAX_BITS-1:0] c,
                                                       input logic up, input int bits);
    logic [CTR_MAX_BITS-1:0] max_v;
    max_v = CTR_MAX_BITS'((1 << bits) - 1);
    if (up) return (c == max_v) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - one saturating up/down prediction counter
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr
);

  logic [CTR_MAX_BITS-1:0] nxt;

  always_comb nxt = ctr_next(CTR_MAX_BITS'(ctr), taken, CTR_BITS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    ctr <= CTR_BITS'(ctr_init(CTR_BITS));
    else if (en) ctr <= nxt[CTR_BITS-1:0];
  end

endmodule

// File: rtl/branch_history_predictor.sv
// rtl/branch_history_predictor.sv - counter-table branch predictor with lookup and resolve ports
// Define BHP_GSHARE_EN to XOR a global outcome history into the lookup index.
module branch_history_predictor
  import bp_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int ENTRIES    = 16,
  parameter int CTR_BITS   = 2,
  parameter int INDEX_LSB  = 2,
  parameter int INSN_BYTES = INSN_BYTES_DEF,
  parameter int IDX_W      = idx_w(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [XLEN-1:0]  lookup_pc,
  input  logic [XLEN-1:0]  lookup_offset,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_next_pc,
  output logic [IDX_W-1:0] pred_index,
  input  logic             resolve_valid,
  input  logic [IDX_W-1:0] resolve_index,
  input  logic [XLEN-1:0]  resolve_pc,
  input  logic [XLEN-1:0]  resolve_offset,
  input  logic             resolve_pred,
  input  logic             resolve_taken,
  output logic             prediction_success,
  output logic             flush,
  output logic [XLEN-1:0]  correct_pc,
  output logic [31:0]      mispredict_count
);

  logic [CTR_BITS-1:0] ctrs [ENTRIES];
  logic [IDX_W-1:0]    look_idx;
  logic                look_taken;
  logic                mispredict;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_tbl
    bp_sat_ctr #(.CTR_BITS(CTR_BITS)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (resolve_valid && (resolve_index == IDX_W'(i))),
      .taken (resolve_taken),
      .ctr   (ctrs[i])
    );
  end

`ifdef BHP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               ghr <= '0;
    else if (resolve_valid) ghr <= (ghr << 1) | IDX_W'(resolve_taken);
  end

  assign look_idx = lookup_pc[INDEX_LSB +: IDX_W] ^ ghr;
`else
  assign look_idx = lookup_pc[INDEX_LSB +: IDX_W];
`endif

  // Table read sees the pre-update value when a resolve hits the same entry.
  assign look_taken = ctrs[look_idx][CTR_BITS-1];
  assign mispredict = resolve_valid && (resolve_pred != resolve_taken);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid         <= 1'b0;
      pred_taken         <= 1'b0;
      pred_next_pc       <= '0;
      pred_index         <= '0;
      prediction_success <= 1'b0;
      flush              <= 1'b0;
      correct_pc         <= '0;
      mispredict_count   <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_taken   <= look_taken;
        pred_next_pc <= look_taken ? lookup_pc + lookup_offset
                                   : lookup_pc + XLEN'(INSN_BYTES);
        pred_index   <= look_idx;
      end
      prediction_success <= resolve_valid && (resolve_pred == resolve_taken);
      flush              <= mispredict;
      if (resolve_valid)
        correct_pc <= resolve_taken ? resolve_pc + resolve_offset
                                    : resolve_pc + XLEN'(INSN_BYTES);
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_history_predictor.sv
// tb/tb_branch_history_predictor.sv - vector table, corner sequences and random model check
module tb_branch_history_predictor;

  localparam int XLEN = 64;
  localparam int ENT  = 16;
  localparam int IW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            lookup_valid = 1'b0;
  logic [XLEN-1:0] lookup_pc = '0, lookup_offset = '0;
  logic            pred_valid, pred_taken;
  logic [XLEN-1:0] pred_next_pc;
  logic [IW-1:0]   pred_index;
  logic            resolve_valid = 1'b0;
  logic [IW-1:0]   resolve_index = '0;
  logic [XLEN-1:0] resolve_pc = '0, resolve_offset = '0;
  logic            resolve_pred = 1'b0, resolve_taken = 1'b0;
  logic            prediction_success, flush;
  logic [XLEN-1:0] correct_pc;
  logic [31:0]     mispredict_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_history_predictor #(.XLEN(XLEN), .ENTRIES(ENT), .CTR_BITS(2), .INDEX_LSB(2),
                             .INSN_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_offset(lookup_offset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .pred_index(pred_index),
    .resolve_valid(resolve_valid), .resolve_index(resolve_index), .resolve_pc(resolve_pc),
    .resolve_offset(resolve_offset), .resolve_pred(resolve_pred), .resolve_taken(resolve_taken),
    .prediction_success(prediction_success), .flush(flush), .correct_pc(correct_pc),
    .mispredict_count(mispredict_count)
  );

  typedef struct {
    logic lv; logic [63:0] pc; logic [63:0] off;
    logic rv; logic [3:0] ri; logic rp; logic rt;
    logic pv; logic pt; logic [63:0] pn; logic [3:0] pi;
    logic s; logic f; logic [63:0] cp; logic [31:0] cnt;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic lv, logic [63:0] pc, logic [63:0] off, logic rv,
                              logic [3:0] ri, logic rp, logic rt, logic pv, logic pt,
                              logic [63:0] pn, logic [3:0] pi, logic s, logic f,
                              logic [63:0] cp, logic [31:0] cnt);
    vec_t v;
    v.lv = lv; v.pc = pc; v.off = off; v.rv = rv; v.ri = ri; v.rp = rp; v.rt = rt;
    v.pv = pv; v.pt = pt; v.pn = pn; v.pi = pi; v.s = s; v.f = f; v.cp = cp; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic pv, logic pt, logic [63:0] pn, logic [3:0] pi,
                           logic s, logic f, logic [63:0] cp, logic [31:0] cnt);
    chk({tag, ".pred_valid"}, 64'(pred_valid), 64'(pv));
    chk({tag, ".pred_taken"}, 64'(pred_taken), 64'(pt));
    chk({tag, ".pred_next_pc"}, pred_next_pc, pn);
    chk({tag, ".pred_index"}, 64'(pred_index), 64'(pi));
    chk({tag, ".prediction_success"}, 64'(prediction_success), 64'(s));
    chk({tag, ".flush"}, 64'(flush), 64'(f));
    chk({tag, ".correct_pc"}, correct_pc, cp);
    chk({tag, ".mispredict_count"}, 64'(mispredict_count), 64'(cnt));
  endtask

  task automatic drive(logic lv, logic [63:0] pc, logic [63:0] off, logic rv,
                       logic [3:0] ri, logic rp, logic rt);
    @(negedge clk);
    lookup_valid = lv; lookup_pc = pc; lookup_offset = off;
    resolve_valid = rv; resolve_index = ri; resolve_pc = pc; resolve_offset = off;
    resolve_pred = rp; resolve_taken = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; lookup_valid = 1'b0; resolve_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model: counters as plain integers 0..3, history as an integer mod ENT.
  int          m_ctr[ENT];
  int          m_hist;
  logic        e_pv, e_pt, e_s, e_f;
  logic [63:0] e_pn, e_cp;
  logic [3:0]  e_pi;
  logic [31:0] e_cnt;

  task automatic model_reset();
    foreach (m_ctr[i]) m_ctr[i] = 1;
    m_hist = 0;
    e_pv = 0; e_pt = 0; e_pn = 0; e_pi = 0; e_s = 0; e_f = 0; e_cp = 0; e_cnt = 0;
  endtask

  task automatic rand_cycle(int n);
    logic lv, rv, rp, rt;
    logic [63:0] pc, off;
    logic [3:0] ri;
    int idx;
    lv = 1'($urandom); rv = 1'($urandom); rp = 1'($urandom); rt = 1'($urandom);
    pc = {$urandom, $urandom}; off = {$urandom, $urandom}; ri = 4'($urandom_range(0, 15));
    if (n % 7 == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
    e_pv = lv;
    if (lv) begin
      idx  = int'((pc / 4) % ENT) ^ m_hist;
      e_pt = (m_ctr[idx] >= 2);
      e_pn = e_pt ? pc + off : pc + 4;
      e_pi = 4'(idx);
    end
    e_s = rv && (rp == rt);
    e_f = rv && (rp != rt);
    if (rv) begin
      e_cp = rt ? pc + off : pc + 4;
      if (e_f && e_cnt != 32'hFFFF_FFFF) e_cnt++;
      if (rt) m_ctr[ri] = (m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3;
      else    m_ctr[ri] = (m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0;
`ifdef BHP_GSHARE_EN
      m_hist = (m_hist * 2 + int'(rt)) % ENT;
`endif
    end
    drive(lv, pc, off, rv, ri, rp, rt);
    check_all($sformatf("rand%0d", n), e_pv, e_pt, e_pn, e_pi, e_s, e_f, e_cp, e_cnt);
  endtask

  initial begin
    vecs[0]  = mk(1, 64'h1000, 64'h16, 0, 0, 0, 0, 1, 0, 64'h1004, 0, 0, 0, 64'h0, 0);
    vecs[1]  = mk(0, 64'h1000, 64'h16, 1, 0, 0, 1, 0, 0, 64'h1004, 0, 0, 1, 64'h1016, 1);
    vecs[2]  = mk(1, 64'h1000, 64'h16, 0, 0, 0, 0, 1, 1, 64'h1016, 0, 0, 0, 64'h1016, 1);
    vecs[3]  = mk(0, 64'h1000, 64'h16, 1, 0, 1, 1, 0, 1, 64'h1016, 0, 1, 0, 64'h1016, 1);
    vecs[4]  = mk(0, 64'h1000, 64'h16, 1, 0, 1, 1, 0, 1, 64'h1016, 0, 1, 0, 64'h1016, 1);
    vecs[5]  = mk(0, 64'h1000, 64'h16, 1, 0, 1, 1, 0, 1, 64'h1016, 0, 1, 0, 64'h1016, 1);
    vecs[6]  = mk(0, 64'h1000, 64'h16, 1, 0, 1, 1, 0, 1, 64'h1016, 0, 1, 0, 64'h1016, 1);
    vecs[7]  = mk(0, 64'h1000, 64'h16, 1, 0, 1, 0, 0, 1, 64'h1016, 0, 0, 1, 64'h1004, 2);
    vecs[8]  = mk(1, 64'h1000, 64'h16, 0, 0, 0, 0, 1, 1, 64'h1016, 0, 0, 0, 64'h1004, 2);
    vecs[9]  = mk(0, 64'h1000, 64'h16, 1, 0, 1, 0, 0, 1, 64'h1016, 0, 0, 1, 64'h1004, 3);
    vecs[10] = mk(1, 64'h1000, 64'h16, 0, 0, 0, 0, 1, 0, 64'h1004, 0, 0, 0, 64'h1004, 3);
    vecs[11] = mk(1, 64'h1000, 64'h16, 1, 0, 0, 1, 1, 0, 64'h1004, 0, 0, 1, 64'h1016, 4);
    vecs[12] = mk(1, 64'h1000, 64'h16, 0, 0, 0, 0, 1, 1, 64'h1016, 0, 0, 0, 64'h1016, 4);
    vecs[13] = mk(1, 64'h203C, 64'h100, 0, 0, 0, 0, 1, 0, 64'h2040, 15, 0, 0, 64'h1016, 4);
    vecs[14] = mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 0, 0, 0, 0, 1, 0, 64'h0, 15, 0, 0,
                  64'h1016, 4);
    vecs[15] = mk(0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1, 15, 0, 0, 0, 0, 64'h0, 15, 1, 0,
                  64'h0, 4);

    do_reset();
    #1;
    check_all("reset", 0, 0, 64'h0, 0, 0, 0, 64'h0, 0);

`ifndef BHP_GSHARE_EN
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].lv, vecs[i].pc, vecs[i].off, vecs[i].rv, vecs[i].ri, vecs[i].rp,
            vecs[i].rt);
      check_all($sformatf("vec%0d", i), vecs[i].pv, vecs[i].pt, vecs[i].pn, vecs[i].pi,
                vecs[i].s, vecs[i].f, vecs[i].cp, vecs[i].cnt);
    end

    // Asynchronous reset mid-sequence, then confirm counters came back weakly not-taken.
    drive(1, 64'h1000, 64'h16, 1, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0; lookup_valid = 1'b0; resolve_valid = 1'b0;
    #1;
    check_all("midrst", 0, 0, 64'h0, 0, 0, 0, 64'h0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 64'h1000, 64'h16, 0, 0, 0, 0);
    check_all("postrst_lk", 1, 0, 64'h1004, 0, 0, 0, 64'h0, 0);
    drive(0, 64'h1000, 64'h16, 1, 0, 1, 1);
    check_all("postrst_rs", 0, 0, 64'h1004, 0, 1, 0, 64'h1016, 0);
    drive(1, 64'h1000, 64'h16, 0, 0, 0, 0);
    check_all("postrst_lk2", 1, 1, 64'h1016, 0, 0, 0, 64'h1016, 0);
`else
    drive(0, 64'h0, 64'h0, 1, 5, 1, 1);
    drive(0, 64'h0, 64'h0, 1, 5, 1, 1);
    drive(1, 64'h1000, 64'h16, 0, 0, 0, 0);
    chk("gshare.pred_index", 64'(pred_index), 64'd3);
    chk("gshare.pred_taken", 64'(pred_taken), 64'd0);
`endif

    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) rand_cycle(n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
